// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared defaults and control-field layout for the MIPS
//                pipeline stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Default bundle geometry used by every stage boundary
    localparam int unsigned c_CTRL_W_DEFAULT   = 24;
    localparam int unsigned c_DATA_W_DEFAULT   = 160;
    localparam int unsigned c_CNT_W_DEFAULT    = 16;

    // All-zero control word: no register write, no memory access, no branch
    localparam logic [23:0] c_NOP_CTRL_DEFAULT = 24'h000000;

    // Stage boundary identifiers
    typedef enum logic [1:0] {
        STAGE_IF_ID  = 2'd0,
        STAGE_ID_EX  = 2'd1,
        STAGE_EX_MEM = 2'd2,
        STAGE_MEM_WB = 2'd3
    } stage_e;

    // ID/EX control field offsets
    localparam int unsigned c_IDEX_REG_WRITE   = 0;
    localparam int unsigned c_IDEX_MEM_TO_REG  = 1;
    localparam int unsigned c_IDEX_MEM_READ    = 2;
    localparam int unsigned c_IDEX_MEM_WRITE   = 3;
    localparam int unsigned c_IDEX_BRANCH      = 4;
    localparam int unsigned c_IDEX_ALU_SRC     = 5;
    localparam int unsigned c_IDEX_REG_DST     = 6;
    localparam int unsigned c_IDEX_ALU_OP_LSB  = 7;
    localparam int unsigned c_IDEX_ALU_OP_W    = 4;
    localparam int unsigned c_IDEX_JUMP        = 11;

    // EX/MEM control field offsets
    localparam int unsigned c_EXMEM_REG_WRITE  = 0;
    localparam int unsigned c_EXMEM_MEM_TO_REG = 1;
    localparam int unsigned c_EXMEM_MEM_READ   = 2;
    localparam int unsigned c_EXMEM_MEM_WRITE  = 3;

    // MEM/WB control field offsets
    localparam int unsigned c_MEMWB_REG_WRITE  = 0;
    localparam int unsigned c_MEMWB_MEM_TO_REG = 1;

    // True when an ID/EX control word changes architectural state
    function automatic logic idex_has_side_effect(input logic [23:0] ctrl);
        return ctrl[c_IDEX_REG_WRITE] | ctrl[c_IDEX_MEM_WRITE] |
               ctrl[c_IDEX_BRANCH]    | ctrl[c_IDEX_JUMP];
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear. Clear wins
//                over increment; the count sticks at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = c_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_MAX = '1;

    logic [WIDTH-1:0] r_count;

    // Count up on request, hold at maximum, clear on reset or clr
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Parametrised pipeline-stage register with valid/ready
//                handshake, stall, flush, bubble insertion and a saturating
//                bubble counter. The control bundle is forced to NOP_CTRL
//                whenever the stage is empty; the data bundle is never
//                cleared after reset.
//  Config      : define PIPE_STAGE_SKID_EN to add a one-entry skid buffer,
//                which removes the out_ready -> in_ready combinational path.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        CTRL_W   = c_CTRL_W_DEFAULT,
    parameter int unsigned        DATA_W   = c_DATA_W_DEFAULT,
    parameter logic [CTRL_W-1:0]  NOP_CTRL = CTRL_W'(c_NOP_CTRL_DEFAULT),
    parameter int unsigned        CNT_W    = c_CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Main (visible) entry
    logic              r_outValid;
    logic [CTRL_W-1:0] r_outCtrl;
    logic [DATA_W-1:0] r_outData;

    // Handshake and load decisions
    logic              w_inReady;
    logic              w_accept;
    logic              w_outFire;
    logic              w_loadMain;
    logic              w_drainMain;
    logic [CTRL_W-1:0] w_mainCtrlNext;
    logic [DATA_W-1:0] w_mainDataNext;

    assign w_outFire = r_outValid & out_ready;
    assign w_accept  = in_valid & w_inReady;

`ifdef PIPE_STAGE_SKID_EN
    // Skid entry: holds one accepted instruction while the main entry waits
    logic              r_skidValid;
    logic [CTRL_W-1:0] r_skidCtrl;
    logic [DATA_W-1:0] r_skidData;
    logic              w_loadFromSkid;
    logic              w_loadSkid;

    // Readiness depends only on local state, never on out_ready
    assign w_inReady = !r_skidValid & !stall & !flush;

    // Decide where an accepted entry lands and whether main refills from skid
    always_comb begin
        w_loadFromSkid = 1'b0;
        w_loadSkid     = 1'b0;
        w_loadMain     = 1'b0;
        w_drainMain    = 1'b0;
        w_mainCtrlNext = in_ctrl;
        w_mainDataNext = in_data;
        if (w_outFire && r_skidValid) begin
            // Skid implies no accept this cycle, so order is preserved
            w_loadFromSkid = 1'b1;
            w_loadMain     = 1'b1;
            w_mainCtrlNext = r_skidCtrl;
            w_mainDataNext = r_skidData;
        end else if (w_accept && (!r_outValid || out_ready)) begin
            w_loadMain     = 1'b1;
        end else if (w_accept) begin
            // Main is full and held by downstream: park the newcomer
            w_loadSkid     = 1'b1;
        end else if (w_outFire) begin
            w_drainMain    = 1'b1;
        end
    end

    // Skid occupancy; dropped on reset and flush
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_skidValid <= 1'b0;
        end else if (w_loadSkid) begin
            r_skidValid <= 1'b1;
        end else if (w_loadFromSkid) begin
            r_skidValid <= 1'b0;
        end
    end

    // Skid payload; needs no reset because it is qualified by r_skidValid
    always_ff @(posedge clk) begin
        if (w_loadSkid) begin
            r_skidCtrl <= in_ctrl;
            r_skidData <= in_data;
        end
    end
`else
    // Accept when the stage is empty or is emptying this cycle
    assign w_inReady = (!r_outValid | out_ready) & !stall & !flush;

    // Single entry: an accept always refills main, otherwise a transfer drains it
    always_comb begin
        w_loadMain     = w_accept;
        w_drainMain    = w_outFire & !w_accept;
        w_mainCtrlNext = in_ctrl;
        w_mainDataNext = in_data;
    end
`endif

    // Valid and control: flush and reset force the NOP control word
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_outValid <= 1'b0;
            r_outCtrl  <= NOP_CTRL;
        end else if (w_loadMain) begin
            r_outValid <= 1'b1;
            r_outCtrl  <= w_mainCtrlNext;
        end else if (w_drainMain) begin
            r_outValid <= 1'b0;
            r_outCtrl  <= NOP_CTRL;
        end
    end

    // Data path: cleared only by reset, untouched by flush and drain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outData <= '0;
        end else if (w_loadMain) begin
            r_outData <= w_mainDataNext;
        end
    end

    // Bubble counter: one tick for every edge the stage sits empty
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_bubbleCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!r_outValid),
        .clr   (cnt_clr),
        .count (bubble_cnt)
    );

    assign in_ready  = w_inReady;
    assign out_valid = r_outValid;
    assign out_ctrl  = r_outCtrl;
    assign out_data  = r_outData;

endmodule : pipe_stage_reg
`default_nettype wire
